hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and writeback selects.
// No logic; no latency; no backpressure.
// Consumers import the whole package.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// One-cycle update latency; clear wins over increment.
// No backpressure; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait stall with timeout.
// Enables/flushes are combinational (zero latency); counters and state update one cycle later.
// A pending memory access freezes the whole pipe until ack; timeout locks into ERR until reset.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_addr_ID,
  input  logic [4:0]       rs2_addr_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_addr_EX,
  input  logic             RegWEn_EX,
  input  logic [1:0]       WBSel_EX,
  input  logic             PCSel_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             en_IF_ID_o,
  output logic             flush_IF_ID_o,
  output logic             en_ID_EX_o,
  output logic             flush_ID_EX_o,
  output logic             en_EX_MEM_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  // wait_cnt counts stalled cycles already taken; the TIMEOUT-th one is the last allowed.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use, mem_stall, flush_rule;
  logic              stall_inc, flush_inc;

  assign load_use  = RegWEn_EX && (WBSel_EX == WB_MEM) && (rd_addr_EX != 5'd0) &&
                     ((rs1_used_ID && (rs1_addr_ID == rd_addr_EX)) ||
                      (rs2_used_ID && (rs2_addr_ID == rd_addr_EX)));
  assign mem_stall = mem_req_MEM && !mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        wait_cnt_nxt = '0;
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_LAST) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Reset forces RUN behaviour even while the state register still reads ERR.
  always_comb begin
    pc_en_o       = 1'b1;
    en_IF_ID_o    = 1'b1;
    flush_IF_ID_o = 1'b0;
    en_ID_EX_o    = 1'b1;
    flush_ID_EX_o = 1'b0;
    en_EX_MEM_o   = 1'b1;
    flush_rule    = 1'b0;
    if (!rst_i && (state == ERR)) begin
      pc_en_o       = 1'b0;
      en_IF_ID_o    = 1'b0;
      en_ID_EX_o    = 1'b0;
      en_EX_MEM_o   = 1'b0;
      flush_IF_ID_o = 1'b1;
      flush_ID_EX_o = 1'b1;
    end else if (mem_stall) begin
      pc_en_o     = 1'b0;
      en_IF_ID_o  = 1'b0;
      en_ID_EX_o  = 1'b0;
      en_EX_MEM_o = 1'b0;
    end else if (PCSel_EX) begin
      flush_IF_ID_o = 1'b1;
      flush_ID_EX_o = 1'b1;
      flush_rule    = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      en_IF_ID_o    = 1'b0;
      flush_ID_EX_o = 1'b1;
    end
  end

  assign stall_inc = (state != ERR) && !pc_en_o;
  assign flush_inc = (state != ERR) && flush_rule;
  assign err_o     = (state == ERR);
  assign state_o   = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (stall_inc),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (flush_inc),
    .cnt   (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a rule-level model.
// Small TIMEOUT and CNT_W so timeout and saturation are reachable quickly.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    r1, r2, rd;
  logic          u1, u2, rwe, pcsel, mreq, ack;
  logic [1:0]    wb;
  logic          pc_en, en_if, fl_if, en_idex, fl_idex, en_exmem, err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  int n_pass = 0;
  int n_tot  = 0;

  // model: 0=run, 1=waiting on memory, 2=error
  int       m_state;
  int       m_consec;
  int       m_stall;
  int       m_flush;
  logic [5:0] e_ctl;
  logic     e_flushrule;
  logic     e_ms;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rs1_addr_ID   (r1),
    .rs2_addr_ID   (r2),
    .rs1_used_ID   (u1),
    .rs2_used_ID   (u2),
    .rd_addr_EX    (rd),
    .RegWEn_EX     (rwe),
    .WBSel_EX      (wb),
    .PCSel_EX      (pcsel),
    .mem_req_MEM   (mreq),
    .mem_ack_i     (ack),
    .pc_en_o       (pc_en),
    .en_IF_ID_o    (en_if),
    .flush_IF_ID_o (fl_if),
    .en_ID_EX_o    (en_idex),
    .flush_ID_EX_o (fl_idex),
    .en_EX_MEM_o   (en_exmem),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt),
    .err_o         (err),
    .state_o       (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic clear_inputs();
    r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; rwe = 0; wb = 0;
    pcsel = 0; mreq = 0; ack = 0;
  endtask

  task automatic set_lu(input logic [4:0] dst, input logic [1:0] sel);
    rwe = 1; wb = sel; rd = dst; r2 = 5'd5; u2 = 1; r1 = 5'd9; u1 = 1;
  endtask

  // Mid-cycle: derive the required outputs from the rules and compare everything.
  task automatic eval();
    logic lu;
    logic [16:0] act, exp;
    @(negedge clk);
    lu = rwe && (wb == 2'b01) && (rd != 0) &&
         ((u1 && r1 == rd) || (u2 && r2 == rd));
    e_ms = mreq && !ack;
    e_flushrule = 1'b0;
    // order: pc, en_if, fl_if, en_idex, fl_idex, en_exmem
    if (m_state == 2 && !rst) e_ctl = 6'b001010;
    else if (e_ms)            e_ctl = 6'b000000;
    else if (pcsel) begin     e_ctl = 6'b111111; e_flushrule = 1'b1; end
    else if (lu)              e_ctl = 6'b000111;
    else                      e_ctl = 6'b110101;
    exp = {e_ctl, CW'(m_stall), CW'(m_flush), (m_state == 2), 2'(m_state)};
    act = {pc_en, en_if, fl_if, en_idex, fl_idex, en_exmem, stall_cnt, flush_cnt, err, state};
    chk("cycle", 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    end else if (m_state != 2) begin
      if (!e_ctl[5] && m_stall < CMAX) m_stall++;
      if (e_flushrule && m_flush < CMAX) m_flush++;
      if (e_ms) begin
        m_consec++;
        m_state = (m_consec >= TO) ? 2 : 1;
      end else begin
        m_consec = 0;
        m_state = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    if (m_state >= 0) eval();
    tick();
    rst = 0;
  endtask

  initial begin
    m_state = -1; m_consec = 0; m_stall = 0; m_flush = 0;
    e_ctl = 6'b110101; e_flushrule = 0; e_ms = 0;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("reset_state", 32'(state), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);

    // load-use on rs2
    set_lu(5'd5, 2'b01);
    eval();
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_en_if", 32'(en_if), 0);
    chk("lu_fl_idex", 32'(fl_idex), 1);
    tick();
    clear_inputs();
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // x0 destination and ALU writeback never stall
    do_reset();
    set_lu(5'd0, 2'b01);
    eval();
    chk("rd0_enables", 32'({pc_en, en_if, en_idex, en_exmem}), 32'hF);
    tick();
    set_lu(5'd5, 2'b00);
    eval();
    chk("alu_enables", 32'({pc_en, en_if, en_idex, en_exmem}), 32'hF);
    tick();
    clear_inputs();
    chk("nostall_cnt", 32'(stall_cnt), 0);

    // branch together with load-use: flush only
    do_reset();
    set_lu(5'd5, 2'b01);
    pcsel = 1;
    eval();
    chk("br_fl_if", 32'(fl_if), 1);
    chk("br_fl_idex", 32'(fl_idex), 1);
    chk("br_pc_en", 32'(pc_en), 1);
    tick();
    clear_inputs();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);

    // memory wait of three cycles then ack
    do_reset();
    mreq = 1; ack = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("mw_enables", 32'({pc_en, en_if, en_idex, en_exmem}), 0);
      tick();
    end
    chk("mw_state", 32'(state), 1);
    ack = 1;
    eval();
    chk("mw_ack_enables", 32'({pc_en, en_if, en_idex, en_exmem}), 32'hF);
    tick();
    clear_inputs();
    chk("mw_stall_cnt", 32'(stall_cnt), 3);
    chk("mw_state_run", 32'(state), 0);

    // timeout into ERR, then reset out of it
    do_reset();
    mreq = 1; ack = 0;
    for (int i = 0; i < TO; i++) begin
      eval();
      chk("to_enables", 32'({pc_en, en_if, en_idex, en_exmem}), 0);
      tick();
    end
    eval();
    chk("to_state_err", 32'(state), 2);
    chk("to_err", 32'(err), 1);
    tick();
    do_reset();
    chk("to_rst_state", 32'(state), 0);
    chk("to_rst_err", 32'(err), 0);
    chk("to_rst_stall", 32'(stall_cnt), 0);
    chk("to_rst_flush", 32'(flush_cnt), 0);

    // stall counter saturation
    do_reset();
    set_lu(5'd5, 2'b01);
    for (int i = 0; i < 20; i++) begin
      eval();
      tick();
    end
    clear_inputs();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      rwe = ($urandom_range(0, 3) != 0);
      wb = 2'($urandom_range(0, 2));
      pcsel = ($urandom_range(0, 6) == 0);
      mreq = ($urandom_range(0, 3) == 0);
      ack = 1'($urandom_range(0, 1));
      if (m_state == 2) rst = ($urandom_range(0, 4) == 0);
      else              rst = ($urandom_range(0, 60) == 0);
      eval();
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
